// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered W-bit ALU with valid/ready handshake, sticky flags and iterative multiply
module alu_pipe #(
    parameter int W   = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           carry_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           carry_out,
    output logic           overflow,
    output logic           negative,
    output logic           zero
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [OPW-1:0] OP_LLS = OPW'(0);
    localparam logic [OPW-1:0] OP_LRS = OPW'(1);
    localparam logic [OPW-1:0] OP_ALS = OPW'(2);
    localparam logic [OPW-1:0] OP_ARS = OPW'(3);
    localparam logic [OPW-1:0] OP_NOT = OPW'(4);
    localparam logic [OPW-1:0] OP_AND = OPW'(5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6);
    localparam logic [OPW-1:0] OP_XOR = OPW'(7);
    localparam logic [OPW-1:0] OP_ADD = OPW'(8);
    localparam logic [OPW-1:0] OP_SUB = OPW'(9);
    localparam logic [OPW-1:0] OP_ADC = OPW'(10);
    localparam logic [OPW-1:0] OP_SBC = OPW'(11);
    localparam logic [OPW-1:0] OP_MUL = OPW'(12);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t           state_q, state_d;
    logic             rdy_en_q;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d, zero_q, zero_d;
    logic [2*W-1:0]   mcand_q, mcand_d, acc_q, acc_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [W-1:0]     op_res, b_eff;
    logic             op_c, op_v, is_mul, cin_eff, accept;
    logic [W:0]       sum;
    logic [2*W-1:0]   step_acc;
    logic             ld_en, ld_c, ld_v;
    logic [W-1:0]     ld_res;

    // Carry-chained ops take the flag currently held, i.e. before this op's own load
    always_comb begin
        b_eff   = ((opcode == OP_SUB) || (opcode == OP_SBC)) ? ~b : b;
        cin_eff = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? carry_q : carry_in;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin_eff};
        op_res  = '0;
        op_c    = 1'b0;
        op_v    = 1'b0;
        is_mul  = 1'b0;
        case (opcode)
            OP_LLS: op_res = a << b;
            OP_LRS: op_res = a >> b;
            OP_ALS: begin
                op_res = a << b;
                op_v   = op_res[W-1] != a[W-1];
            end
            OP_ARS: op_res = $signed(a) >>> b;
            OP_NOT: op_res = ~a;
            OP_AND: op_res = a & b;
            OP_OR:  op_res = a | b;
            OP_XOR: op_res = a ^ b;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                op_res = sum[W-1:0];
                op_c   = sum[W];
                op_v   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_MUL: is_mul = 1'b1;
            default: op_res = '0;
        endcase
    end

    assign in_ready = rdy_en_q && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign accept   = in_valid && in_ready;
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ld_en    = 1'b0;
        ld_res   = op_res;
        ld_c     = op_c;
        ld_v     = op_v;
        case (state_q)
            IDLE, HOLD: begin
                if ((state_q == HOLD) && out_ready) state_d = IDLE;
                if (accept) begin
                    if (is_mul) begin
                        state_d  = BUSY;
                        mcand_d  = {{W{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d = HOLD;
                        ld_en   = 1'b1;
                    end
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    state_d = HOLD;
                    ld_en   = 1'b1;
                    ld_res  = step_acc[W-1:0];
                    ld_c    = |step_acc[2*W-1:W];
                    ld_v    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        result_d = ld_en ? ld_res : result_q;
        carry_d  = ld_en ? ld_c : carry_q;
        ovf_d    = ld_en ? ld_v : ovf_q;
        neg_d    = ld_en ? ld_res[W-1] : neg_q;
        zero_d   = ld_en ? (ld_res == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;
    localparam int W   = 4;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] opcode;
    logic [W-1:0]   a, b;
    logic           carry_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           carry_out, overflow, negative, zero;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .negative(negative), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op, input int av, input int bv, input logic cin);
        in_valid = 1'b1;
        opcode   = OPW'(op);
        a        = W'(av);
        b        = W'(bv);
        carry_in = cin;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int res, input logic c, input logic v,
                             input logic n, input logic z);
        check({tag, ".valid"}, 32'(out_valid), 1);
        check({tag, ".res"},   32'(result), 32'(res));
        check({tag, ".c"},     32'(carry_out), 32'(c));
        check({tag, ".v"},     32'(overflow), 32'(v));
        check({tag, ".n"},     32'(negative), 32'(n));
        check({tag, ".z"},     32'(zero), 32'(z));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
        carry_in = 1'b0; out_ready = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 0);
        tick(); tick();
        check("rst.valid", 32'(out_valid), 0);
        check("rst.res", 32'(result), 0);
        check("rst.flags", 32'({carry_out, overflow, negative, zero}), 0);
        rst_n = 1'b1;
        #1;
        check("rel.in_ready0", 32'(in_ready), 0);
        tick();
        check("rel.in_ready1", 32'(in_ready), 1);

        issue(8, 7, 1, 1'b0);
        check_out("add7p1", 8, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(8, 15, 1, 1'b0);
        check_out("addF", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(10, 0, 0, 1'b0);
        check_out("adc", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(9, 3, 5, 1'b1);
        check_out("sub", 14, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(11, 5, 2, 1'b1);
        check_out("sbc", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(2, 5, 1, 1'b0);
        check_out("als_ov", 10, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(2, 3, 1, 1'b0);
        check_out("als", 6, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(13, 7, 7, 1'b1);
        check_out("bad_op", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(7, 12, 10, 1'b0);
        check_out("xor", 6, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(12, 5, 3, 1'b0);
        for (int i = 0; i < W; i++) begin
            check($sformatf("mul.busy_rdy%0d", i), 32'(in_ready), 0);
            check($sformatf("mul.busy_val%0d", i), 32'(out_valid), 0);
            if (i < W - 1) tick();
        end
        tick();
        check_out("mul5x3", 15, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(12, 6, 3, 1'b0);
        repeat (W) tick();
        check_out("mul6x3", 2, 1'b1, 1'b0, 1'b0, 1'b0);

        issue(12, 5, 3, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 0);
        check("arst.res", 32'(result), 0);
        check("arst.c", 32'(carry_out), 0);
        check("arst.in_ready", 32'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        repeat (W + 2) begin
            check("arst.no_valid", 32'(out_valid), 0);
            tick();
        end
        check("arst.ready_back", 32'(in_ready), 1);

        issue(3, 8, 2, 1'b0);
        check_out("ars2", 14, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(3, 8, 9, 1'b0);
        check_out("ars9", 15, 1'b0, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = OPW'(0); a = W'(3); b = W'(5);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall.rdy%0d", i), 32'(in_ready), 0);
            check_out($sformatf("stall%0d", i), 15, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_out("lls5", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("idle.valid", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the team's combinational W-bit ALU. Accepts operations through a valid/ready handshake and produces a registered result with sticky flags. Adds an iterative unsigned multiply, and carry-chained ADC/SBC that use the stored carry flag. Sits between the instruction-decode stage and the register-file write-back.

Parameters:
W, 4, operand/result width in bits (W >= 2)
OPW, 4, opcode width in bits (OPW >= 4)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
opcode  input  OPW  operation select
a  input  W  operand 1
b  input  W  operand 2; shift amount for shift ops
carry_in  input  1  carry for ADD/SUB
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  W  registered result
carry_out  output  1  registered carry flag
overflow  output  1  registered signed-overflow flag
negative  output  1  registered negative flag, equals result[W-1]
zero  output  1  registered zero flag, set when result == 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, and 1 from the first clock after release; out_valid=0; result=0; carry_out=0; overflow=0; negative=0; zero=0; multiply counter/accumulator cleared. Reset during BUSY aborts the multiply; no result is emitted.
- Handshake: an input is accepted on a rising edge with in_valid && in_ready. A result is consumed on a rising edge with out_valid && out_ready. result and flags are held stable while out_valid && !out_ready.
- States: IDLE, BUSY, HOLD.
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: multiply iterating; in_ready=0, out_valid=0.
  - HOLD: out_valid=1; in_ready=out_ready, giving back-to-back throughput.
- Transitions:
  - Accepted single-cycle op (from IDLE or HOLD): load result and flags, go to HOLD. Latency is 1 cycle.
  - Accepted MUL: go to BUSY for W cycles (one shift-add step per cycle), then load result and flags and go to HOLD. Latency is W+1 cycles from acceptance to out_valid.
  - HOLD with out_ready and no accept: go to IDLE.
- Opcodes (shift amount s = b as unsigned):
  - 0 LLS: a << s.
  - 1 LRS: a >> s, zero fill.
  - 2 ALS: a << s; overflow=1 when result[W-1] != a[W-1].
  - 3 ARS: a >>> s, sign fill.
  - For s >= W: LLS, LRS and ALS give 0; ARS gives all copies of a[W-1].
  - 4 NOT: ~a.
  - 5 AND, 6 OR, 7 XOR: bitwise a with b.
  - 8 ADD: a + b + carry_in.
  - 9 SUB: a + ~b + carry_in. carry_in=1 gives plain a-b. carry_out=1 means no borrow.
  - 10 ADC: as ADD, but uses the stored carry_out flag in place of carry_in.
  - 11 SBC: as SUB, but uses the stored carry_out flag in place of carry_in.
  - 12 MUL: unsigned a*b. result = low W bits; carry_out=1 when the high W bits are nonzero; overflow=0.
  - 13 .. 2^OPW-1: result=0; carry_out=0; overflow=0; zero=1; the op still completes with 1-cycle latency.
- Flags:
  - ADD/ADC/SUB/SBC: carry_out = carry out of bit W-1; overflow = signed overflow (operand signs equal and result sign differs, evaluated with the inverted b for subtraction).
  - Shifts and logic ops: carry_out=0; overflow=0, except ALS as defined above.
  - negative and zero are always derived from the final result.
  - Flags change only when a result is loaded. ADC/SBC read the flag value held before their own load, including when issued back-to-back from HOLD.
- Arithmetic is modulo 2^W; no exceptions or saturation.

Test Plan:
- Reset with rst_n=0 mid-stream -> all outputs 0 immediately (asynchronous); in_ready=1 one cycle after release.
- W=4, ADD a=7, b=1, carry_in=0 -> next cycle out_valid=1, result=8, negative=1, overflow=1, carry_out=0, zero=0.
- W=4, ADD a=0xF, b=1, carry_in=0 -> result=0, carry_out=1, zero=1. Then ADC a=0, b=0 issued back-to-back -> result=1, carry_out=0.
- W=4, SUB a=3, b=5, carry_in=1 -> result=0xE, carry_out=0, negative=1, overflow=0.
- W=4, MUL a=5, b=3 -> in_ready=0 for 4 cycles, out_valid on cycle 5, result=0xF, carry_out=0. MUL a=6, b=3 -> result=0x2, carry_out=1. Assert rst_n low during BUSY -> no out_valid.
- W=4, ARS a=0x8, b=2 -> 0xE; ARS a=0x8, b=9 -> 0xF; LLS a=0x3, b=5 -> 0. Hold out_ready=0 for 3 cycles -> result, flags and out_valid stable, in_ready=0.
